// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// seg_scan_ctrl: scan controller for a 4-digit common-anode seven-segment display.
// Each digit slot is a BLANK dead-time period followed by a DRIVE period.
// New display words are buffered in a single pending register and take effect only
// at frame boundaries, so a frame never mixes old and new digits.
// Build option: define LEADING_ZERO_BLANK_EN to darken leading zero digits.
module seg_scan_ctrl #(
    parameter int DRIVE_CYC = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic        ca,
    output logic        cb,
    output logic        cc,
    output logic        cd,
    output logic        ce,
    output logic        cf,
    output logic        cg,
    output logic        dp,
    output logic        frame_tick
);
    // state    | meaning
    // ST_BLANK | all anodes off, dead time before the digit idx_q is driven
    // ST_DRIVE | digit idx_q driven with its active nibble
    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    localparam int MAX_CYC = (DRIVE_CYC > BLANK_CYC) ? DRIVE_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          boundary;

    logic [15:0]   active_q, active_d;
    logic [3:0]    active_dp_q, active_dp_d;
    logic [15:0]   pend_q, pend_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_full_q, pend_full_d;

    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    nib;
    logic          lz_hide;

    // Active-low {g,f,e,d,c,b,a} hex glyphs.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0:    seg_decode = 7'b1000000;
            4'h1:    seg_decode = 7'b1111001;
            4'h2:    seg_decode = 7'b0100100;
            4'h3:    seg_decode = 7'b0110000;
            4'h4:    seg_decode = 7'b0011001;
            4'h5:    seg_decode = 7'b0010010;
            4'h6:    seg_decode = 7'b0000010;
            4'h7:    seg_decode = 7'b1111000;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0010000;
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b0000011;
            4'hC:    seg_decode = 7'b1000110;
            4'hD:    seg_decode = 7'b0100001;
            4'hE:    seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    // Slot sequencing: BLANK then DRIVE per digit; boundary marks entry to BLANK of digit 0.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + 1'b1;
        boundary = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d  = ST_BLANK;
                    cnt_d    = '0;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end
            end
            default: state_d = ST_BLANK;
        endcase
        tick_d = boundary;
    end

    // Pending word moves to active only at a boundary; accepts only land in pending.
    always_comb begin
        active_d    = active_q;
        active_dp_d = active_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        if (boundary && pend_full_q) begin
            active_d    = pend_q;
            active_dp_d = pend_dp_q;
            pend_full_d = 1'b0;
        end
        if (load_valid && !pend_full_q) begin
            pend_d      = load_data;
            pend_dp_d   = load_dp;
            pend_full_d = 1'b1;
        end
    end

    // Leading-zero suppression: digit i>0 goes dark when nibbles i..3 are zero and its dp is off.
    always_comb begin
        lz_hide = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd1:    lz_hide = (active_q[15:4] == 12'h000) && !active_dp_q[1];
            2'd2:    lz_hide = (active_q[15:8] == 8'h00) && !active_dp_q[2];
            2'd3:    lz_hide = (active_q[15:12] == 4'h0) && !active_dp_q[3];
            default: lz_hide = 1'b0;
        endcase
`else
        lz_hide = 1'b0;
`endif
    end

    // Pin drive for the current slot; registered below for one cycle of latency.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        nib   = active_q[{idx_q, 2'b00} +: 4];
        if (state_q == ST_DRIVE && digit_en[idx_q] && !lz_hide) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_decode(nib);
            dp_d  = ~active_dp_q[idx_q];
        end
    end

    // FSM and timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BLANK;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    // Display data and pending-slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q    <= 16'h0000;
            active_dp_q <= 4'h0;
            pend_q      <= 16'h0000;
            pend_dp_q   <= 4'h0;
            pend_full_q <= 1'b0;
        end else begin
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
        end
    end

    // Output pin registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 4'b1111;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign load_ready = ~pend_full_q;
    assign frame_tick = tick_q;
    assign an         = an_q;
    assign ca         = seg_q[0];
    assign cb         = seg_q[1];
    assign cc         = seg_q[2];
    assign cd         = seg_q[3];
    assign ce         = seg_q[4];
    assign cf         = seg_q[5];
    assign cg         = seg_q[6];
    assign dp         = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for seg_scan_ctrl with DRIVE_CYC=6, BLANK_CYC=2 (slot 8, frame 32).
module tb_seg_scan_ctrl;
    localparam int DRV   = 6;
    localparam int BLK   = 2;
    localparam int SLOT  = DRV + BLK;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic [3:0]  load_dp = 4'h0;
    logic [3:0]  digit_en = 4'hF;
    logic        load_ready;
    logic [3:0]  an;
    logic        ca, cb, cc, cd, ce, cf, cg, dp;
    logic        frame_tick;
    logic [6:0]  seg_obs;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       care;
    } exp_t;
    exp_t sb[$];

    seg_scan_ctrl #(.DRIVE_CYC(DRV), .BLANK_CYC(BLK)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_dp(load_dp), .digit_en(digit_en),
        .an(an), .ca(ca), .cb(cb), .cc(cc), .cd(cd), .ce(ce), .cf(cf), .cg(cg),
        .dp(dp), .frame_tick(frame_tick)
    );

    assign seg_obs = {cg, cf, ce, cd, cc, cb, ca};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        case (n)
            4'h0: exp_seg = 7'b1000000;  4'h1: exp_seg = 7'b1111001;
            4'h2: exp_seg = 7'b0100100;  4'h3: exp_seg = 7'b0110000;
            4'h4: exp_seg = 7'b0011001;  4'h5: exp_seg = 7'b0010010;
            4'h6: exp_seg = 7'b0000010;  4'h7: exp_seg = 7'b1111000;
            4'h8: exp_seg = 7'b0000000;  4'h9: exp_seg = 7'b0010000;
            4'hA: exp_seg = 7'b0001000;  4'hB: exp_seg = 7'b0000011;
            4'hC: exp_seg = 7'b1000110;  4'hD: exp_seg = 7'b0100001;
            4'hE: exp_seg = 7'b0000110;  default: exp_seg = 7'b0001110;
        endcase
    endfunction

    function automatic bit lz_hidden(input logic [15:0] d, input logic [3:0] dpm, input int s);
        bit allz;
        allz = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (s == 0) return 1'b0;
        for (int j = s; j < 4; j++)
            if (d[4*j +: 4] != 4'h0) allz = 1'b0;
        return allz && !dpm[s];
`else
        allz = 1'b0;
        return allz;
`endif
    endfunction

    // Expected pin values for one frame, starting the cycle after frame_tick.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dpm, input logic [3:0] en);
        exp_t e;
        for (int p = 0; p < FRAME; p++) begin
            int s = p / SLOT;
            int w = p % SLOT;
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, care: 1'b1};
            if (w >= BLK) begin
                if (en[s] && !lz_hidden(d, dpm, s)) begin
                    e.an  = 4'hF & ~(4'h1 << s);
                    e.seg = exp_seg(d[4*s +: 4]);
                    e.dp  = ~dpm[s];
                end else begin
                    e.care = 1'b0;
                end
            end
            sb.push_back(e);
        end
    endtask

    // Offer a word and hold load_valid until the handshake edge has passed.
    task automatic load_word(input logic [15:0] d, input logic [3:0] dpm);
        int n = 0;
        @(negedge clk);
        load_data  = d;
        load_dp    = dpm;
        load_valid = 1'b1;
        while (!load_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) begin
            total++; bad++;
            $display("FAIL load_accept: load_ready=%b required=1", load_ready);
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Advance to the next frame_tick strictly after the current negedge.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        if (!frame_tick) begin
            total++; bad++;
            $display("FAIL wait_tick: frame_tick=%b required=1 after %0d cycles", frame_tick, n);
        end
    endtask

    // Pop and compare one expected entry per cycle; drops load_valid after the first edge.
    task automatic scan_check(input int n, input string tag, output logic rdy_first);
        exp_t e;
        rdy_first = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rdy_first  = load_ready;
                load_valid = 1'b0;
            end
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL %s_sb_empty: cycle %0d has no expectation", tag, i);
            end else begin
                e = sb.pop_front();
                total++;
                if (an !== e.an) begin
                    bad++;
                    $display("FAIL %s_an cycle %0d: got %b required %b", tag, i, an, e.an);
                end
                if (e.care) begin
                    total++;
                    if (seg_obs !== e.seg) begin
                        bad++;
                        $display("FAIL %s_seg cycle %0d: got %b required %b", tag, i, seg_obs, e.seg);
                    end
                    total++;
                    if (dp !== e.dp) begin
                        bad++;
                        $display("FAIL %s_dp cycle %0d: got %b required %b", tag, i, dp, e.dp);
                    end
                end
            end
        end
    endtask

    task automatic check_idle(input string tag);
        total++;
        if (an !== 4'hF || seg_obs !== 7'h7F || dp !== 1'b1 || load_ready !== 1'b1 || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL %s: an=%b seg=%b dp=%b rdy=%b tick=%b required 1111 1111111 1 1 0",
                     tag, an, seg_obs, dp, load_ready, frame_tick);
        end
    endtask

    task automatic test_reset();
        bit tick_seen = 1'b0;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_idle("reset_hold");
        rst = 1'b0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (frame_tick) tick_seen = 1'b1;
        end
        total++;
        if (tick_seen) begin
            bad++;
            $display("FAIL first_frame_tick: got 1 required 0 during first frame");
        end
        total++;
        if (an !== 4'b1011 || seg_obs !== 7'b1000000) begin
            bad++;
            $display("FAIL drive_idx2: an=%b seg=%b required 1011 1000000", an, seg_obs);
        end
        #2 rst = 1'b1;
        #1 check_idle("async_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic r;
        load_word(16'h1234, 4'h0);
        push_frame(16'h1234, 4'h0, 4'hF);
        wait_tick();
        scan_check(FRAME, "basic", r);
    endtask

    task automatic test_back_to_back();
        logic r;
        int n = 0;
        @(negedge clk);
        load_data = 16'hA5A5; load_dp = 4'h0; load_valid = 1'b1;
        while (!load_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready_after_accept: got %b required 0", load_ready);
        end
        load_data = 16'h00FF;
        push_frame(16'hA5A5, 4'h0, 4'hF);
        push_frame(16'h00FF, 4'h0, 4'hF);
        wait_tick();
        total++;
        if (load_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready_at_boundary: got %b required 1", load_ready);
        end
        scan_check(2 * FRAME, "b2b", r);
        total++;
        if (r !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second_accept: load_ready=%b required 0 after boundary", r);
        end
        total++;
        if (frame_tick !== 1'b1) begin
            bad++;
            $display("FAIL b2b_frame_period: frame_tick=%b required 1", frame_tick);
        end
    endtask

    task automatic test_digit_en();
        logic r;
        digit_en = 4'b0101;
        load_word(16'h8888, 4'h0);
        push_frame(16'h8888, 4'h0, 4'b0101);
        wait_tick();
        scan_check(FRAME, "digit_en", r);
        digit_en = 4'hF;
    endtask

    task automatic test_dp();
        logic r;
        load_word(16'h0000, 4'b0010);
        push_frame(16'h0000, 4'b0010, 4'hF);
        wait_tick();
        scan_check(FRAME, "dp", r);
    endtask

    task automatic test_leading_zero();
        logic r;
        load_word(16'h0070, 4'h0);
        push_frame(16'h0070, 4'h0, 4'hF);
        wait_tick();
        scan_check(FRAME, "lz_0070", r);
        load_word(16'h0000, 4'h0);
        push_frame(16'h0000, 4'h0, 4'hF);
        wait_tick();
        scan_check(FRAME, "lz_0000", r);
    endtask

    task automatic test_reset_discard();
        logic r;
        load_word(16'h9999, 4'hF);
        #2 rst = 1'b1;
        #1;
        total++;
        if (load_ready !== 1'b1) begin
            bad++;
            $display("FAIL discard_ready: got %b required 1", load_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        push_frame(16'h0000, 4'h0, 4'hF);
        wait_tick();
        scan_check(FRAME, "discard", r);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_digit_en();
        test_dp();
        test_leading_zero();
        test_reset_discard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
